laser_score: RTL and testbench
==============================

# laser_score

Scoring stage directly downstream of the two-circle laser placement block. It snoops the same 40-point X/Y stream the placer loads after reset, then waits for the placer's DONE. On DONE it latches the two circle centers and counts, one point per cycle, how many target points each circle covers and how many the union covers. The result is a registered score plus a sticky VALID, used for on-chip self-check and for comparing placer revisions.

## Interface
- NPTS, 40: number of points in the stream after reset.
- RADIUS_SQ, 16: coverage threshold on squared Euclidean distance (inclusive).
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- X  in  4  point x-coordinate, shared with placer input.
- Y  in  4  point y-coordinate, shared with placer input.
- C1X, C1Y, C2X, C2Y  in  4 each  circle centers from the placer; sampled only on the latch edge.
- DONE_IN  in  1  placer DONE.
- CNT1  out  6  points covered by circle 1.
- CNT2  out  6  points covered by circle 2.
- SCORE  out  6  points covered by circle 1 OR circle 2.
- VALID  out  1  CNT1/CNT2/SCORE final; sticky until RST.
- BUSY  out  1  high in LOAD and EVAL.

## Operation
- States: IDLE, LOAD, WAIT, EVAL, HOLD.
- RST high: go to IDLE; clear point index, accumulators, CNT1, CNT2, SCORE, VALID and BUSY to 0.
- IDLE: on the first edge with RST low, store point 0 from X/Y and go to LOAD, index = 1.
- LOAD: store X/Y into entry[index] on each edge. After entry NPTS-1 is stored, go to WAIT. DONE_IN is ignored in LOAD.
- WAIT: on the first edge with DONE_IN=1, latch C1X/C1Y/C2X/C2Y into internal registers, clear accumulators and index, and go to EVAL.
- EVAL: each edge processes entry[index] against the latched centers.
  - dx = |px−cx| and dy = |py−cy|, each 4-bit unsigned.
  - d² = dx² + dy², at least 9 bits (max 450). No truncation or wrap is permitted.
  - hitN = (d²N ≤ RADIUS_SQ).
  - acc1 += hit1; acc2 += hit2; accU += (hit1 | hit2).
  - Duplicate points are counted individually.
- After entry NPTS-1 is processed, write CNT1/CNT2/SCORE with the final sums (including that last point), set VALID=1, and go to HOLD.
- HOLD: outputs frozen. DONE_IN is ignored, including when it is held high or re-pulsed. Only RST leaves HOLD.
- Outputs CNT1/CNT2/SCORE stay 0 until the HOLD transition; intermediate sums are never exposed.

## Timing
- Point k (0-based) is sampled on the (k+1)-th rising edge with RST low. LOAD→WAIT happens on edge NPTS.
- Latch edge E is the first edge in WAIT with DONE_IN=1. DONE_IN asserted before WAIT is entered has no effect. If DONE_IN is still high once in WAIT, it latches on the first WAIT edge.
- EVAL processes point i on edge E+1+i.
- VALID, CNT1, CNT2 and SCORE update on edge E+NPTS, so VALID is visible NPTS cycles after the latch edge.
- BUSY: high from the edge entering LOAD until the edge entering WAIT, low in WAIT, high from edge E until edge E+NPTS, low in HOLD.
- RST mid-LOAD, mid-EVAL or in HOLD: the next edge returns to the reset state. No partial result is retained, and the next point stream restarts at point 0.
- Centers changing on C*X/C*Y after edge E do not affect the result.

## Test plan
- All 40 points (0,0); centers C1=(0,0), C2=(15,15); DONE_IN pulsed 5 cycles after LOAD ends -> CNT1=40, CNT2=0, SCORE=40, VALID rises exactly 40 cycles after the latch edge.
- Boundary: 20 points (4,0) and 20 points (3,3); C1=(0,0), C2=(15,15) -> CNT1=20 (d²=16 covered, d²=18 not), CNT2=0, SCORE=20.
- Width/wrap: all points (0,0); C1=(15,6) (d²=261, wraps to 5 in 8 bits), C2=(2,2) -> CNT1=0, CNT2=40, SCORE=40.
- Overlap: 10 points (5,5), 10 points (9,5), 20 points (0,15); C1=(6,5), C2=(8,5) -> CNT1=20, CNT2=20, SCORE=20.
- DONE_IN high during LOAD and held high through HOLD -> latch occurs on the first WAIT edge, results computed once and stay stable in HOLD; centers changed after latch -> no effect.
- RST pulsed at the 20th EVAL cycle, then a new 40-point stream and DONE_IN -> outputs cleared to 0 and BUSY=0 on the reset edge, VALID stays low until the new evaluation completes, and the new results reflect only the second stream.

Source files
------------

// File: rtl/laser_score.sv
// laser_score: scores a two-circle placement by snooping the placer's point
// stream, latching the circle centers on DONE_IN, then counting the points
// covered by each circle and by their union, one point per cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset; first edge stores point 0
// S_LOAD  | storing points 1..NPTS-1 from X/Y
// S_WAIT  | stream captured, waiting for placer DONE_IN
// S_EVAL  | scoring one stored point per edge against the latched centers
// S_HOLD  | results final and frozen until RST
module laser_score #(
  parameter int NPTS      = 40,
  parameter int RADIUS_SQ = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE_IN,
  output logic [5:0] CNT1,
  output logic [5:0] CNT2,
  output logic [5:0] SCORE,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EVAL,
    S_HOLD
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
  localparam logic [8:0] R_SQ     = 9'(RADIUS_SQ);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] acc1_q, acc1_d;
  logic [5:0] acc2_q, acc2_d;
  logic [5:0] accu_q, accu_d;
  logic [3:0] c1x_q, c1x_d, c1y_q, c1y_d;
  logic [3:0] c2x_q, c2x_d, c2y_q, c2y_d;
  logic [5:0] cnt1_q, cnt1_d;
  logic [5:0] cnt2_q, cnt2_d;
  logic [5:0] score_q, score_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic [7:0] pts_q [NPTS];
  logic       pt_we;
  logic [7:0] cur_pt;
  logic [8:0] d1_sq, d2_sq;
  logic       hit1, hit2;

  // Squared distance kept at full 9-bit width so far-away centers never wrap
  // back inside the radius.
  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] dx2, dy2;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dx2 = {4'b0, dx} * {4'b0, dx};
    dy2 = {4'b0, dy} * {4'b0, dy};
    return {1'b0, dx2} + {1'b0, dy2};
  endfunction

  // Coverage test of the currently indexed stored point against both centers.
  always_comb begin
    cur_pt = pts_q[idx_q];
    d1_sq  = dist_sq(cur_pt[3:0], cur_pt[7:4], c1x_q, c1y_q);
    d2_sq  = dist_sq(cur_pt[3:0], cur_pt[7:4], c2x_q, c2y_q);
    hit1   = (d1_sq <= R_SQ);
    hit2   = (d2_sq <= R_SQ);
  end

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    accu_d  = accu_q;
    c1x_d   = c1x_q;
    c1y_d   = c1y_q;
    c2x_d   = c2x_q;
    c2y_d   = c2y_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    score_d = score_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    pt_we   = 1'b0;

    if (RST) begin
      state_d = S_IDLE;
      idx_d   = '0;
      acc1_d  = '0;
      acc2_d  = '0;
      accu_d  = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
      score_d = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pt_we   = 1'b1;
          idx_d   = 6'd1;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          pt_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        S_WAIT: begin
          if (DONE_IN) begin
            c1x_d   = C1X;
            c1y_d   = C1Y;
            c2x_d   = C2X;
            c2y_d   = C2Y;
            idx_d   = '0;
            acc1_d  = '0;
            acc2_d  = '0;
            accu_d  = '0;
            busy_d  = 1'b1;
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          acc1_d = acc1_q + {5'b0, hit1};
          acc2_d = acc2_q + {5'b0, hit2};
          accu_d = accu_q + {5'b0, hit1 | hit2};
          if (idx_q == LAST_IDX) begin
            cnt1_d  = acc1_d;
            cnt2_d  = acc2_d;
            score_d = accu_d;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_HOLD;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        S_HOLD: begin
          state_d = S_HOLD;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, accumulator, latched-center and output registers.
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    idx_q   <= idx_d;
    acc1_q  <= acc1_d;
    acc2_q  <= acc2_d;
    accu_q  <= accu_d;
    c1x_q   <= c1x_d;
    c1y_q   <= c1y_d;
    c2x_q   <= c2x_d;
    c2y_q   <= c2y_d;
    cnt1_q  <= cnt1_d;
    cnt2_q  <= cnt2_d;
    score_q <= score_d;
    valid_q <= valid_d;
    busy_q  <= busy_d;
  end

  // Point storage; contents are don't-care until rewritten after reset.
  always_ff @(posedge CLK) begin
    if (pt_we) begin
      pts_q[idx_q] <= {Y, X};
    end
  end

  assign CNT1  = cnt1_q;
  assign CNT2  = cnt2_q;
  assign SCORE = score_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_laser_score.sv
// Self-checking bench for laser_score: directed and random point streams
// scored against a plain-arithmetic coverage model.
module tb_laser_score;

  localparam int N = 40;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] X, Y, C1X, C1Y, C2X, C2Y;
  logic       DONE_IN;
  logic [5:0] CNT1, CNT2, SCORE;
  logic       VALID, BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] px [N];
  logic [3:0] py [N];
  int exp1, exp2, expu;

  laser_score dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .DONE_IN(DONE_IN),
    .CNT1(CNT1), .CNT2(CNT2), .SCORE(SCORE), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: count points within sqrt(16) of each center using signed ints.
  function automatic void model(input int c1x, input int c1y, input int c2x, input int c2y);
    int a, b;
    exp1 = 0; exp2 = 0; expu = 0;
    for (int i = 0; i < N; i++) begin
      a = (int'(px[i]) - c1x) * (int'(px[i]) - c1x) + (int'(py[i]) - c1y) * (int'(py[i]) - c1y);
      b = (int'(px[i]) - c2x) * (int'(px[i]) - c2x) + (int'(py[i]) - c2y) * (int'(py[i]) - c2y);
      if (a <= 16) exp1++;
      if (b <= 16) exp2++;
      if (a <= 16 || b <= 16) expu++;
    end
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    DONE_IN = 1'b0;
    step();
    step();
    chk("rst_cnt1", CNT1, 0);
    chk("rst_score", SCORE, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b0;
  endtask

  task automatic load_stream();
    for (int k = 0; k < N; k++) begin
      X = px[k];
      Y = py[k];
      step();
      chk("busy_load", BUSY, (k < N - 1) ? 1 : 0);
    end
    chk("valid_after_load", VALID, 0);
    X = 4'($urandom);
    Y = 4'($urandom);
  endtask

  task automatic eval_run(input int c1x, input int c1y, input int c2x, input int c2y,
                          input int pre_wait, input bit keep_done);
    int n;
    logic [5:0] s1, s2, su;
    C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
    model(c1x, c1y, c2x, c2y);
    if (pre_wait > 0) begin
      DONE_IN = 1'b0;
      repeat (pre_wait) step();
      chk("busy_wait", BUSY, 0);
      chk("valid_wait", VALID, 0);
    end
    DONE_IN = 1'b1;
    step();
    chk("busy_latch", BUSY, 1);
    if (!keep_done) DONE_IN = 1'b0;
    C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
    n = 0;
    while (VALID !== 1'b1 && n < 60) begin
      step();
      n++;
      if (n == 20) begin
        chk("score_hidden_mid_eval", SCORE, 0);
        chk("busy_eval", BUSY, 1);
      end
    end
    chk("valid_latency", n, 40);
    chk("cnt1", CNT1, exp1);
    chk("cnt2", CNT2, exp2);
    chk("score", SCORE, expu);
    chk("busy_hold", BUSY, 0);
    s1 = CNT1; s2 = CNT2; su = SCORE;
    for (int i = 0; i < 4; i++) begin
      if (!keep_done) DONE_IN = 1'($urandom);
      C1X = 4'($urandom); C2Y = 4'($urandom);
      step();
    end
    chk("hold_cnt1", CNT1, s1);
    chk("hold_cnt2", CNT2, s2);
    chk("hold_score", SCORE, su);
    chk("hold_valid", VALID, 1);
    chk("hold_busy", BUSY, 0);
    DONE_IN = 1'b0;
  endtask

  task automatic rand_stream();
    for (int i = 0; i < N; i++) begin
      px[i] = 4'($urandom_range(0, 15));
      py[i] = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    RST = 1'b1; DONE_IN = 1'b0;
    X = '0; Y = '0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;

    // all points at origin, DONE 5 cycles after load
    for (int i = 0; i < N; i++) begin px[i] = 4'd0; py[i] = 4'd0; end
    do_reset();
    load_stream();
    eval_run(0, 0, 15, 15, 5, 1'b0);
    chk("t1_cnt1_abs", CNT1, 40);
    chk("t1_score_abs", SCORE, 40);

    // inclusive boundary: d^2=16 covered, d^2=18 not
    for (int i = 0; i < N; i++) begin
      px[i] = (i < 20) ? 4'd4 : 4'd3;
      py[i] = (i < 20) ? 4'd0 : 4'd3;
    end
    do_reset();
    load_stream();
    eval_run(0, 0, 15, 15, 2, 1'b0);
    chk("t2_cnt1_abs", CNT1, 20);

    // wide distance must not wrap
    for (int i = 0; i < N; i++) begin px[i] = 4'd0; py[i] = 4'd0; end
    do_reset();
    load_stream();
    eval_run(15, 6, 2, 2, 1, 1'b0);
    chk("t3_cnt1_abs", CNT1, 0);
    chk("t3_cnt2_abs", CNT2, 40);

    // overlapping circles
    for (int i = 0; i < N; i++) begin
      if (i < 10)      begin px[i] = 4'd5; py[i] = 4'd5;  end
      else if (i < 20) begin px[i] = 4'd9; py[i] = 4'd5;  end
      else             begin px[i] = 4'd0; py[i] = 4'd15; end
    end
    do_reset();
    load_stream();
    eval_run(6, 5, 8, 5, 3, 1'b0);
    chk("t4_score_abs", SCORE, 20);

    // DONE_IN high through load and hold
    rand_stream();
    do_reset();
    DONE_IN = 1'b1;
    load_stream();
    eval_run(7, 7, 3, 11, 0, 1'b1);

    // random streams
    for (int t = 0; t < 4; t++) begin
      rand_stream();
      do_reset();
      load_stream();
      eval_run($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 6), 1'b0);
    end

    // reset at the 20th EVAL cycle, then a fresh stream
    for (int i = 0; i < N; i++) begin px[i] = 4'd1; py[i] = 4'd1; end
    do_reset();
    load_stream();
    C1X = 4'd1; C1Y = 4'd1; C2X = 4'd1; C2Y = 4'd1;
    DONE_IN = 1'b1;
    step();
    DONE_IN = 1'b0;
    repeat (20) step();
    chk("mid_eval_busy", BUSY, 1);
    RST = 1'b1;
    step();
    chk("rst_edge_busy", BUSY, 0);
    chk("rst_edge_valid", VALID, 0);
    chk("rst_edge_score", SCORE, 0);
    RST = 1'b0;
    rand_stream();
    for (int i = 0; i < 10; i++) begin px[i] = 4'd12; py[i] = 4'd2; end
    load_stream();
    eval_run(12, 2, 4, 9, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
